// File: rtl/xbar_id_tracker_pkg.sv
// xbar_pkg: shared definitions for the crossbar ID tracker.
//   clog2_min1  : max(1, $clog2(n)), keeps every field at least one bit wide
//   DEF_*       : default ID-table geometry
//   id_entry_t  : one ID-table entry at the default geometry
package xbar_pkg;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_ID_WIDTH  = 4;
  localparam int unsigned DEF_ID_DEPTH  = 1 << DEF_ID_WIDTH;
  localparam int unsigned DEF_SLAVES    = 2;
  localparam int unsigned DEF_MAX_OUTST = 4;
  localparam int unsigned DEF_CNT_W     = clog2_min1(DEF_MAX_OUTST + 1);
  localparam int unsigned DEF_DEST_W    = clog2_min1(DEF_SLAVES);

  typedef struct packed {
    logic [DEF_CNT_W-1:0]  count;
    logic [DEF_DEST_W-1:0] dest;
  } id_entry_t;

endpackage

// File: rtl/xbar_id_tracker_entry.sv
// xbar_id_tracker_entry: in-flight counter and destination for one AXI ID.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : one transaction accepted on this ID (already qualified)
//   dec        : one transaction completed on this ID (already qualified)
//   new_dest   : destination slave recorded on inc
//   count/dest : current in-flight count and its destination slave
//   full       : count has reached MAX_OUTST
//   busy       : count is non-zero
module xbar_id_tracker_entry #(
  parameter int unsigned CNT_W     = 3,
  parameter int unsigned DEST_W    = 1,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              dec,
  input  logic [DEST_W-1:0] new_dest,
  output logic [CNT_W-1:0]  count,
  output logic [DEST_W-1:0] dest,
  output logic              full,
  output logic              busy
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTST);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEST_W-1:0] dest_q, dest_d;

  // inc and dec together leave the count alone but still retarget dest
  always_comb begin
    count_d = count_q;
    dest_d  = dest_q;
    unique case ({inc, dec})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (inc) dest_d = new_dest;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      dest_q  <= '0;
    end else begin
      count_q <= count_d;
      dest_q  <= dest_d;
    end
  end

  assign count = count_q;
  assign dest  = dest_q;
  assign full  = (count_q == MAX_C);
  assign busy  = (count_q != '0);

endmodule

// File: rtl/xbar_id_tracker.sv
// xbar_id_tracker: per-master outstanding-transaction tracker for one
// address channel. Allows up to MAX_OUTST in-flight per ID, all to one slave,
// and at most MAX_TOTAL in flight overall.
//   ACLK, ARESETn          : clock, asynchronous active-low reset
//   req_valid/id/dest      : candidate at the address FIFO head
//   req_block              : candidate may not be forwarded this cycle
//   req_accept             : candidate forwarded this cycle
//   rsp_done/rsp_id        : completion of a transaction on rsp_id
//   total_outst            : in-flight count across all IDs
//   id_busy                : per-ID non-zero count
//   proto_err              : sticky accept-while-blocked / orphan completion
module xbar_id_tracker
  import xbar_pkg::*;
#(
  parameter int unsigned ID_WIDTH  = 4,
  parameter int unsigned SLAVES    = 2,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned MAX_TOTAL = 8
) (
  input  logic                                ACLK,
  input  logic                                ARESETn,
  input  logic                                req_valid,
  input  logic [ID_WIDTH-1:0]                 req_id,
  input  logic [clog2_min1(SLAVES)-1:0]       req_dest,
  output logic                                req_block,
  input  logic                                req_accept,
  input  logic                                rsp_done,
  input  logic [ID_WIDTH-1:0]                 rsp_id,
  output logic [clog2_min1(MAX_TOTAL+1)-1:0]  total_outst,
  output logic [(1<<ID_WIDTH)-1:0]            id_busy,
  output logic                                proto_err
);

  localparam int unsigned DEPTH = 1 << ID_WIDTH;
  localparam int unsigned CW    = clog2_min1(MAX_OUTST + 1);
  localparam int unsigned DW    = clog2_min1(SLAVES);
  localparam int unsigned TW    = clog2_min1(MAX_TOTAL + 1);
  localparam logic [TW-1:0] MAX_T = TW'(MAX_TOTAL);

  logic [CW-1:0]    cnt_w  [DEPTH];
  logic [DW-1:0]    dest_w [DEPTH];
  logic [DEPTH-1:0] full_w, busy_w;
  logic [DEPTH-1:0] inc_sel, dec_sel;

  logic             accept, done_ok;
  logic [TW-1:0]    total_q, total_d;
  logic             perr_q;

  assign req_block = req_valid &
                     (full_w[req_id] |
                      (busy_w[req_id] & (dest_w[req_id] != req_dest)) |
                      (total_q == MAX_T));

  assign accept  = req_accept & ~req_block;
  assign done_ok = rsp_done & busy_w[rsp_id];

  always_comb begin
    inc_sel = '0;
    dec_sel = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      inc_sel[i] = accept  && (req_id == ID_WIDTH'(i));
      dec_sel[i] = done_ok && (rsp_id == ID_WIDTH'(i));
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    xbar_id_tracker_entry #(
      .CNT_W    (CW),
      .DEST_W   (DW),
      .MAX_OUTST(MAX_OUTST)
    ) u_entry (
      .clk     (ACLK),
      .rst_n   (ARESETn),
      .inc     (inc_sel[g]),
      .dec     (dec_sel[g]),
      .new_dest(req_dest),
      .count   (cnt_w[g]),
      .dest    (dest_w[g]),
      .full    (full_w[g]),
      .busy    (busy_w[g])
    );
  end

  always_comb begin
    total_d = total_q;
    unique case ({accept, done_ok})
      2'b10:   total_d = total_q + TW'(1);
      2'b01:   total_d = total_q - TW'(1);
      default: total_d = total_q;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      total_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      total_q <= total_d;
      if ((req_accept & req_block) | (rsp_done & ~busy_w[rsp_id]))
        perr_q <= 1'b1;
    end
  end

  assign total_outst = total_q;
  assign id_busy     = busy_w;
  assign proto_err   = perr_q;

endmodule

// File: tb/tb_xbar_id_tracker.sv
module tb_xbar_id_tracker;
  import xbar_pkg::*;

  localparam int MAXO = 4;
  localparam int MAXT = 8;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  req_id = '0;
  logic [0:0]  req_dest = '0;
  logic        req_block;
  logic        req_accept = 1'b0;
  logic        rsp_done = 1'b0;
  logic [3:0]  rsp_id = '0;
  logic [3:0]  total_outst;
  logic [15:0] id_busy;
  logic        proto_err;

  int tests = 0;
  int failed = 0;

  xbar_id_tracker #(
    .ID_WIDTH (4),
    .SLAVES   (2),
    .MAX_OUTST(MAXO),
    .MAX_TOTAL(MAXT)
  ) dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .req_valid  (req_valid),
    .req_id     (req_id),
    .req_dest   (req_dest),
    .req_block  (req_block),
    .req_accept (req_accept),
    .rsp_done   (rsp_done),
    .rsp_id     (rsp_id),
    .total_outst(total_outst),
    .id_busy    (id_busy),
    .proto_err  (proto_err)
  );

  always #5 ACLK = ~ACLK;

  // Behavioural model: per-ID table plus global counters
  id_entry_t tbl [16];
  int        m_total = 0;
  bit        m_perr  = 0;

  initial for (int i = 0; i < 16; i++) tbl[i] = '0;

  function automatic bit m_block();
    if (!req_valid) return 0;
    if (int'(tbl[req_id].count) == MAXO) return 1;
    if (tbl[req_id].count != 0 && tbl[req_id].dest != req_dest) return 1;
    return m_total == MAXT;
  endfunction

  function automatic logic [15:0] m_busy();
    logic [15:0] v = '0;
    for (int i = 0; i < 16; i++) v[i] = (tbl[i].count != 0);
    return v;
  endfunction

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < 16; i++) tbl[i] = '0;
      m_total = 0;
      m_perr  = 0;
    end else begin
      bit blk, acc, don;
      blk = m_block();
      acc = req_accept && !blk;
      don = rsp_done && tbl[rsp_id].count != 0;
      if ((req_accept && blk) || (rsp_done && tbl[rsp_id].count == 0)) m_perr = 1;
      if (acc) begin
        tbl[req_id].count = tbl[req_id].count + 1;
        tbl[req_id].dest  = req_dest;
        m_total++;
      end
      if (don) begin
        tbl[rsp_id].count = tbl[rsp_id].count - 1;
        m_total--;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge ACLK) begin
    check("model_block", int'(req_block), int'(m_block()));
    check("model_total", int'(total_outst), m_total);
    check("model_busy", int'(id_busy), int'(m_busy()));
    check("model_perr", int'(proto_err), int'(m_perr));
  end

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_req(input int id, input int dest, input bit acc);
    req_valid  = 1'b1;
    req_id     = 4'(id);
    req_dest   = 1'(dest);
    req_accept = acc;
  endtask

  task automatic set_rsp(input bit done, input int id);
    rsp_done = done;
    rsp_id   = 4'(id);
  endtask

  task automatic idle();
    req_valid  = 1'b0;
    req_accept = 1'b0;
    rsp_done   = 1'b0;
  endtask

  initial begin
    int drain [8] = '{0, 1, 3, 4, 5, 6, 7, 8};
    #1;
    check("rst_total", int'(total_outst), 0);
    check("rst_busy", int'(id_busy), 0);
    check("rst_perr", int'(proto_err), 0);
    check("rst_block", int'(req_block), 0);
    repeat (2) cyc();
    ARESETn = 1'b1;
    cyc();

    // ID 3 to slave 1, four times; fifth is blocked
    set_req(3, 1, 1);
    repeat (4) cyc();
    req_accept = 1'b0;
    #1;
    check("t1_total", int'(total_outst), 4);
    check("t1_busy", int'(id_busy), 16'h0008);
    check("t1_block5", int'(req_block), 1);
    req_valid = 1'b0;
    set_rsp(1, 3);
    repeat (4) cyc();
    set_rsp(0, 0);
    #1;
    check("t1_drain", int'(total_outst), 0);

    // Same-ID redirect
    set_req(5, 0, 1);
    cyc();
    set_req(5, 1, 0);
    #1;
    check("t2_redirect_blk", int'(req_block), 1);
    set_rsp(1, 5);
    #1;
    check("t2_no_bypass", int'(req_block), 1);
    cyc();
    set_rsp(0, 0);
    #1;
    check("t2_unblocked", int'(req_block), 0);
    req_accept = 1'b1;
    cyc();
    set_req(5, 0, 0);
    #1;
    check("t2_dest_now1", int'(req_block), 1);
    check("t2_total", int'(total_outst), 1);
    check("t2_busy", int'(id_busy), 16'h0020);
    req_valid = 1'b0;
    set_rsp(1, 5);
    cyc();
    set_rsp(0, 0);

    // Total cap
    for (int i = 0; i < 8; i++) begin
      set_req(i, 0, 1);
      cyc();
    end
    set_req(8, 0, 0);
    #1;
    check("t3_total", int'(total_outst), 8);
    check("t3_busy", int'(id_busy), 16'h00FF);
    check("t3_cap_blk", int'(req_block), 1);
    set_rsp(1, 2);
    #1;
    check("t3_cap_no_bypass", int'(req_block), 1);
    cyc();
    set_rsp(0, 0);
    #1;
    check("t3_cap_free", int'(req_block), 0);
    check("t3_total7", int'(total_outst), 7);
    req_accept = 1'b1;
    cyc();
    req_accept = 1'b0;
    #1;
    check("t3_total8", int'(total_outst), 8);
    req_valid = 1'b0;
    foreach (drain[k]) begin
      set_rsp(1, drain[k]);
      cyc();
    end
    set_rsp(0, 0);
    #1;
    check("t3_drain", int'(total_outst), 0);
    check("t3_drain_busy", int'(id_busy), 0);

    // Simultaneous accept and completion
    set_req(4, 0, 1);
    repeat (2) cyc();
    set_rsp(1, 4);
    cyc();
    idle();
    #1;
    check("t4_same_total", int'(total_outst), 2);
    check("t4_same_busy", int'(id_busy), 16'h0010);
    check("t4_same_perr", int'(proto_err), 0);
    set_req(4, 0, 1);
    repeat (2) cyc();
    req_accept = 1'b0;
    #1;
    check("t4_count4_total", int'(total_outst), 4);
    check("t4_count4_blk", int'(req_block), 1);
    set_req(6, 0, 1);
    set_rsp(1, 4);
    cyc();
    idle();
    #1;
    check("t4_diff_total", int'(total_outst), 4);
    check("t4_diff_busy", int'(id_busy), 16'h0050);

    // Async reset mid-burst
    set_req(7, 1, 1);
    repeat (2) cyc();
    req_accept = 1'b0;
    #1;
    check("t5_total6", int'(total_outst), 6);
    @(posedge ACLK);
    #3;
    ARESETn = 1'b0;
    #1;
    check("t5_rst_total", int'(total_outst), 0);
    check("t5_rst_busy", int'(id_busy), 0);
    check("t5_rst_perr", int'(proto_err), 0);
    check("t5_rst_block", int'(req_block), 0);
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    idle();
    cyc();

    // Error cases
    set_rsp(1, 9);
    cyc();
    set_rsp(0, 0);
    #1;
    check("t6_orphan_perr", int'(proto_err), 1);
    check("t6_orphan_total", int'(total_outst), 0);
    set_req(1, 1, 1);
    cyc();
    set_req(1, 0, 1);
    #1;
    check("t6_forced_blk", int'(req_block), 1);
    cyc();
    idle();
    #1;
    check("t6_forced_total", int'(total_outst), 1);
    check("t6_forced_busy", int'(id_busy), 16'h0002);
    repeat (3) cyc();
    check("t6_perr_sticky", int'(proto_err), 1);
    ARESETn = 1'b0;
    cyc();
    ARESETn = 1'b1;
    #1;
    check("t6_perr_cleared", int'(proto_err), 0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
